// File: rtl/hilo_mdu_if.sv
// EX-stage connection to the HI/LO multiply/divide unit: instruction fields in,
// stall request, MF read data and HI/LO state out.
interface hilo_mdu_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic [5:0]       op_i;
    logic [5:0]       funct_i;
    logic [WIDTH-1:0] rs_val_i;
    logic [WIDTH-1:0] rt_val_i;
    logic             flush_i;
    logic             stall_o;
    logic [WIDTH-1:0] mf_data_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output valid_i, op_i, funct_i, rs_val_i, rt_val_i, flush_i,
        input  stall_o, mf_data_o, hi_o, lo_o
    );

    modport slave (
        input  valid_i, op_i, funct_i, rs_val_i, rt_val_i, flush_i,
        output stall_o, mf_data_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_mdu.sv
// HI/LO multiply/divide unit for the EX stage: fixed-latency multiply,
// one-bit-per-cycle restoring divide, MTHI/MTLO writes and MFHI/MFLO reads.
module hilo_mdu #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic      clk,
    input  logic      rst,
    hilo_mdu_if.slave bus
);
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic [WIDTH-1:0] mul_a, mul_b;
    logic             sgn_q, div_q, neg_quo, neg_rem;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;

    logic [WIDTH:0]     shifted;
    logic               fit;
    logic [WIDTH-1:0]   rem_n, quo_n;
    logic [2*WIDTH-1:0] prod;

    logic r_type, is_mul, is_div, is_sgn, mt_hi, mt_lo, mf_hi, mf_lo;
    logic live, accept, div_zero;

    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic sgn);
        logic signed [2*WIDTH-1:0] ae, be;
        ae = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        be = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ae * be;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] a, input logic sgn);
        return (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign r_type = (bus.op_i == 6'b000000);
    assign is_mul = r_type && (bus.funct_i == F_MULT || bus.funct_i == F_MULTU);
    assign is_div = r_type && (bus.funct_i == F_DIV || bus.funct_i == F_DIVU);
    assign is_sgn = (bus.funct_i == F_MULT) || (bus.funct_i == F_DIV);
    assign mt_hi  = r_type && (bus.funct_i == F_MTHI);
    assign mt_lo  = r_type && (bus.funct_i == F_MTLO);
    assign mf_hi  = r_type && (bus.funct_i == F_MFHI);
    assign mf_lo  = r_type && (bus.funct_i == F_MFLO);

    assign live     = bus.valid_i && !bus.flush_i && (state == IDLE);
    assign accept   = live && (is_mul || is_div);
    assign div_zero = is_div && (bus.rt_val_i == '0);

    // A flush in BUSY releases the pipeline in the same cycle it is seen.
    assign bus.stall_o   = !rst && (accept || (state == BUSY && !bus.flush_i));
    assign bus.mf_data_o = (rst || !bus.valid_i) ? '0 :
                           mf_hi ? hi_q : (mf_lo ? lo_q : '0);
    assign bus.hi_o = hi_q;
    assign bus.lo_o = lo_q;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        fit     = (shifted >= {1'b0, dvs_q});
        rem_n   = fit ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
        quo_n   = {quo_q[WIDTH-2:0], fit};
        prod    = mul_full(mul_a, mul_b, sgn_q);
    end

    // Operand and divide working registers: loaded on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            mul_a   <= bus.rs_val_i;
            mul_b   <= bus.rt_val_i;
            sgn_q   <= is_sgn;
            div_q   <= is_div;
            neg_quo <= is_sgn && (bus.rs_val_i[WIDTH-1] ^ bus.rt_val_i[WIDTH-1]);
            neg_rem <= is_sgn && bus.rs_val_i[WIDTH-1];
            rem_q   <= '0;
            quo_q   <= magnitude(bus.rs_val_i, is_sgn);
            dvs_q   <= magnitude(bus.rt_val_i, is_sgn);
        end else if (state == BUSY && div_q) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && div_zero) begin
                        hi_q  <= bus.rs_val_i;
                        lo_q  <= '1;
                        state <= DONE;
                    end else if (accept) begin
                        cnt   <= is_div ? CNT_W'(WIDTH) : CNT_W'(MUL_LAT);
                        state <= BUSY;
                    end else if (live && mt_hi) begin
                        hi_q <= bus.rs_val_i;
                    end else if (live && mt_lo) begin
                        lo_q <= bus.rs_val_i;
                    end
                end
                BUSY: begin
                    if (bus.flush_i) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                            // The divide's last quotient bit is formed in this same cycle.
                            if (div_q) begin
                                hi_q <= apply_sign(rem_n, neg_rem);
                                lo_q <= apply_sign(quo_n, neg_quo);
                            end else begin
                                hi_q <= prod[2*WIDTH-1:WIDTH];
                                lo_q <= prod[WIDTH-1:0];
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: directed instruction sequence, a transaction-level
// reference of HI/LO and stall timing, and a per-cycle compare process.
module tb_hilo_mdu;
    localparam int W       = 32;
    localparam int MUL_LAT = 3;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    hilo_mdu_if #(.WIDTH(W)) bus ();
    hilo_mdu #(.WIDTH(W), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
    int          m_busy;
    bit          m_done;

    function automatic bit is_md(input logic [5:0] fn);
        return fn == F_MULT || fn == F_MULTU || fn == F_DIV || fn == F_DIVU;
    endfunction

    // Plain 64-bit arithmetic: {HI, LO} for a multiply, {remainder, quotient} for a divide.
    function automatic logic [63:0] ref_result(input logic [5:0] fn, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        q = 0;
        r = 0;
        case (fn)
            F_MULT:  return sa * sb;
            F_MULTU: return ua * ub;
            F_DIV:   begin q = sa / sb; r = sa % sb; end
            F_DIVU:  begin q = ua / ub; r = ua % ub; end
            default: ;
        endcase
        return {r[31:0], q[31:0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_hi <= '0; m_lo <= '0; m_busy <= 0; m_done <= 1'b0;
        end else if (m_busy > 0) begin
            if (bus.flush_i) m_busy <= 0;
            else begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_hi <= m_res_hi; m_lo <= m_res_lo; m_done <= 1'b1;
                end
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (bus.valid_i && !bus.flush_i && bus.op_i == 6'd0) begin
            if ((bus.funct_i == F_DIV || bus.funct_i == F_DIVU) && bus.rt_val_i == 0) begin
                m_hi <= bus.rs_val_i; m_lo <= '1; m_done <= 1'b1;
            end else if (is_md(bus.funct_i)) begin
                {m_res_hi, m_res_lo} <= ref_result(bus.funct_i, bus.rs_val_i, bus.rt_val_i);
                m_busy <= (bus.funct_i == F_MULT || bus.funct_i == F_MULTU) ? MUL_LAT : W;
            end else if (bus.funct_i == F_MTHI) m_hi <= bus.rs_val_i;
            else if (bus.funct_i == F_MTLO) m_lo <= bus.rs_val_i;
        end
    end

    function automatic logic exp_stall();
        if (rst) return 1'b0;
        if (m_busy > 0) return !bus.flush_i;
        return !m_done && bus.valid_i && !bus.flush_i && bus.op_i == 6'd0 && is_md(bus.funct_i);
    endfunction

    function automatic logic [31:0] exp_mf();
        if (rst || !bus.valid_i || bus.op_i != 6'd0) return '0;
        if (bus.funct_i == F_MFHI) return m_hi;
        if (bus.funct_i == F_MFLO) return m_lo;
        return '0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_stall", 32'(bus.stall_o), 32'(exp_stall()));
            check("cyc_mf", bus.mf_data_o, exp_mf());
            check("cyc_hi", bus.hi_o, m_hi);
            check("cyc_lo", bus.lo_o, m_lo);
        end
    end

    task automatic start(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        bus.valid_i  = 1'b1;
        bus.op_i     = 6'd0;
        bus.funct_i  = fn;
        bus.rs_val_i = a;
        bus.rt_val_i = b;
    endtask

    // Hold the instruction until a cycle without stall, then retire it.
    task automatic finish(output int stalls);
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.stall_o) begin
                @(posedge clk);
                #1;
                bus.valid_i = 1'b0;
                bus.funct_i = 6'd0;
                return;
            end
            stalls++;
        end
        n_chk++;
        $display("FAIL timeout at %0t: stall_o still high after %0d cycles", $time, stalls);
        bus.valid_i = 1'b0;
    endtask

    task automatic run(input string name, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input int exp_stalls,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int s;
        start(fn, a, b);
        finish(s);
        check({name, "_stalls"}, 32'(s), 32'(exp_stalls));
        check({name, "_hi"}, bus.hi_o, exp_hi);
        check({name, "_lo"}, bus.lo_o, exp_lo);
    endtask

    initial begin
        int s;
        bus.valid_i = 1'b1; bus.op_i = 6'd0; bus.funct_i = F_DIV;
        bus.rs_val_i = 32'd5; bus.rt_val_i = 32'd0; bus.flush_i = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_stall", 32'(bus.stall_o), 32'd0);
        check("rst_hi", bus.hi_o, 32'd0);
        check("rst_lo", bus.lo_o, 32'd0);
        check("rst_mf", bus.mf_data_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.valid_i = 1'b0;

        run("t1_mult",  F_MULT,  32'hFFFFFFFF, 32'd2, 4, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run("t1b_multu", F_MULTU, 32'hFFFFFFFF, 32'd2, 4, 32'h00000001, 32'hFFFFFFFE);
        run("t1c_mult_nn", F_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 4, 32'd0, 32'd15);
        run("t2_div",   F_DIV,   32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("t2b_divu", F_DIVU,  32'd7, 32'd2, 33, 32'd1, 32'd3);
        run("t2c_ovf",  F_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000);
        run("t2d_divneg", F_DIV, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD);
        run("t2e_divu_big", F_DIVU, 32'hFFFFFFFF, 32'h10, 33, 32'hF, 32'h0FFFFFFF);
        run("t3_div0",  F_DIV,   32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF);

        // Divide aborted by a flush in its 10th BUSY cycle, then a multiply right behind it.
        run("t4_mthi", F_MTHI, 32'hAAAA, 32'd0, 0, 32'hAAAA, 32'hFFFFFFFF);
        run("t4_mtlo", F_MTLO, 32'hBBBB, 32'd0, 0, 32'hAAAA, 32'hBBBB);
        start(F_DIV, 32'd100, 32'd7);
        @(negedge clk);
        check("t4_t0_stall", 32'(bus.stall_o), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("t4_flush_stall", 32'(bus.stall_o), 32'd0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("t4_keep_hi", bus.hi_o, 32'hAAAA);
        check("t4_keep_lo", bus.lo_o, 32'hBBBB);
        start(F_MULT, 32'd3, 32'd4);
        @(negedge clk);
        check("t4_mult_accept", 32'(bus.stall_o), 32'd1);
        finish(s);
        check("t4_mult_stalls", 32'(s), 32'd3);
        check("t4_mult_lo", bus.lo_o, 32'd12);

        run("t5_mthi", F_MTHI, 32'h1234, 32'd0, 0, 32'h1234, 32'd12);
        start(F_MFHI, 32'd0, 32'd0);
        @(negedge clk);
        check("t5_mfhi", bus.mf_data_o, 32'h1234);
        finish(s);
        start(F_MTLO, 32'hDEAD, 32'd0);
        bus.flush_i = 1'b1;
        finish(s);
        bus.flush_i = 1'b0;
        check("t5_mtlo_flush_lo", bus.lo_o, 32'd12);
        start(F_MFLO, 32'd0, 32'd0);
        @(negedge clk);
        check("t5_mflo", bus.mf_data_o, 32'd12);
        finish(s);

        // Non-R-type opcode carrying a MULT funct must be ignored.
        start(F_MULT, 32'd9, 32'd9);
        bus.op_i = 6'h23;
        @(negedge clk);
        check("op_other_stall", 32'(bus.stall_o), 32'd0);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.op_i = 6'd0;
        check("op_other_lo", bus.lo_o, 32'd12);

        // Reset in the middle of a divide; the held divide restarts afterwards.
        start(F_DIV, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_stall", 32'(bus.stall_o), 32'd0);
        @(posedge clk);
        #1;
        check("t6_hi", bus.hi_o, 32'd0);
        check("t6_lo", bus.lo_o, 32'd0);
        @(negedge clk);
        check("t6_rst2_stall", 32'(bus.stall_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        finish(s);
        check("t6_redo_stalls", 32'(s), 32'd33);
        check("t6_redo_hi", bus.hi_o, 32'd2);
        check("t6_redo_lo", bus.lo_o, 32'd14);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
